// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared encodings and helpers for the memory bus interface.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    function automatic int lane_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Byte-enable generation, store replication and load extract/extend.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_bus_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int OFF_W  = lane_off_w(DATA_W)
)(
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [BE_W-1:0]   mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              top;

    always_comb begin
        mask    = '1;
        wdata_o = wdata_i;
        keep    = '1;
        top     = 1'b0;
        shifted = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                mask    = BE_W'(1'b1);
                wdata_o = {BE_W{wdata_i[7:0]}};
                keep    = DATA_W'(8'hFF);
                top     = shifted[7];
            end
            SZ_HALF: begin
                mask    = BE_W'(2'b11);
                wdata_o = {(DATA_W/16){wdata_i[15:0]}};
                keep    = DATA_W'(16'hFFFF);
                top     = shifted[15];
            end
            SZ_WORD: begin
                mask    = BE_W'(4'hF);
                wdata_o = {(DATA_W/32){wdata_i[31:0]}};
                keep    = DATA_W'(32'hFFFF_FFFF);
                top     = shifted[31];
            end
            default: ;
        endcase
        be_o = mask << off_i;
        // Full-width accesses have keep all ones, so the fill term vanishes.
        rdata_o = (shifted & keep) | ((sign_i && top) ? ~keep : '0);
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_if
// Purpose  : Request/done memory bus front end with lane steering and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_if
    import mem_bus_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  ADDR_W  = 32,
    parameter int  TIMEOUT = 255,
    localparam int BE_W    = DATA_W / 8,
    localparam int OFF_W   = lane_off_w(DATA_W)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              wr_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic              busy_o,
    output logic              mem_cs_o,
    output logic              mem_we_o,
    output logic              mem_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;

    logic              is_idle;
    logic              misaligned;
    logic              illegal;
    logic              leave;
    logic [1:0]        lane_size;
    logic [OFF_W-1:0]  lane_off;
    logic [BE_W-1:0]   lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;

    // The single lane block serves the request inputs at accept time and the
    // latched request while the access is in flight.
    assign is_idle   = (state_q == ST_IDLE);
    assign lane_size = is_idle ? size_i : size_q;
    assign lane_off  = is_idle ? addr_i[OFF_W-1:0] : off_q;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane (
        .size_i  (lane_size),
        .sign_i  (sign_q),
        .off_i   (lane_off),
        .wdata_i (wdata_i),
        .rdata_i (mem_rdata_i),
        .be_o    (lane_be),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    always_comb begin
        case (size_i)
            SZ_HALF:  misaligned = addr_i[0];
            SZ_WORD:  misaligned = |addr_i[1:0];
            SZ_DWORD: misaligned = |addr_i[2:0];
            default:  misaligned = 1'b0;
        endcase
    end

    assign illegal = (size_i == SZ_DWORD) && (DATA_W == 32);
    assign leave   = mem_ready_i || (cnt_q == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        size_d   = size_q;
        sign_d   = sign_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        cs_d     = cs_q;
        we_d     = we_q;
        oe_d     = oe_q;
        maddr_d  = maddr_q;
        be_d     = be_q;
        mwdata_d = mwdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    size_d = size_i;
                    sign_d = sign_i;
                    off_d  = addr_i[OFF_W-1:0];
                    if (illegal) begin
                        state_d = ST_FAULT;
                        err_d   = 1'b1;
                        code_d  = ERR_SIZE;
                    end else if (misaligned) begin
                        state_d = ST_FAULT;
                        err_d   = 1'b1;
                        code_d  = ERR_MISALIGN;
                    end else begin
                        state_d  = ST_ACCESS;
                        cnt_d    = '0;
                        code_d   = ERR_NONE;
                        cs_d     = 1'b1;
                        we_d     = wr_i;
                        oe_d     = !wr_i;
                        maddr_d  = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        be_d     = lane_be;
                        mwdata_d = lane_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready_i) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    if (oe_q) begin
                        rdata_d = lane_rdata;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (leave) begin
                    cs_d     = 1'b0;
                    we_d     = 1'b0;
                    oe_d     = 1'b0;
                    maddr_d  = '0;
                    be_d     = '0;
                    mwdata_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            size_q   <= '0;
            sign_q   <= 1'b0;
            off_q    <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            maddr_q  <= '0;
            be_q     <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            maddr_q  <= maddr_d;
            be_q     <= be_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign busy_o      = !is_idle;
    assign mem_cs_o    = cs_q;
    assign mem_we_o    = we_q;
    assign mem_oe_o    = oe_q;
    assign mem_addr_o  = maddr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = mwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_if
// Purpose  : Self-checking bench for mem_bus_if (32-bit and 64-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_if;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 32-bit instance
    logic        a_req, a_wr, a_sign, a_mem_ready;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_mem_rdata;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic        a_done, a_err, a_busy, a_cs, a_we, a_oe;
    logic [1:0]  a_err_code;
    logic [3:0]  a_be;

    // 64-bit instance
    logic        b_req, b_wr, b_sign, b_mem_ready;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_maddr;
    logic [63:0] b_wdata, b_mem_rdata, b_rdata, b_mwdata;
    logic        b_done, b_err, b_busy, b_cs, b_we, b_oe;
    logic [1:0]  b_err_code;
    logic [7:0]  b_be;

    mem_bus_if #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) u_dut32 (
        .clk(clk), .rst(rst), .req_i(a_req), .wr_i(a_wr), .size_i(a_size),
        .sign_i(a_sign), .addr_i(a_addr), .wdata_i(a_wdata), .rdata_o(a_rdata),
        .done_o(a_done), .err_o(a_err), .err_code_o(a_err_code), .busy_o(a_busy),
        .mem_cs_o(a_cs), .mem_we_o(a_we), .mem_oe_o(a_oe), .mem_addr_o(a_maddr),
        .mem_be_o(a_be), .mem_wdata_o(a_mwdata), .mem_rdata_i(a_mem_rdata),
        .mem_ready_i(a_mem_ready)
    );

    mem_bus_if #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO)) u_dut64 (
        .clk(clk), .rst(rst), .req_i(b_req), .wr_i(b_wr), .size_i(b_size),
        .sign_i(b_sign), .addr_i(b_addr), .wdata_i(b_wdata), .rdata_o(b_rdata),
        .done_o(b_done), .err_o(b_err), .err_code_o(b_err_code), .busy_o(b_busy),
        .mem_cs_o(b_cs), .mem_we_o(b_we), .mem_oe_o(b_oe), .mem_addr_o(b_maddr),
        .mem_be_o(b_be), .mem_wdata_o(b_mwdata), .mem_rdata_i(b_mem_rdata),
        .mem_ready_i(b_mem_ready)
    );

    // ---------------- reference model (byte-oriented) ----------------
    function automatic logic [31:0] m_load(input logic [1:0] size, input bit sign,
                                           input int off, input logic [31:0] mem);
        logic [31:0] v;
        int n;
        n = 1 << size;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem[8*(off+i) +: 8];
        if (sign && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input int off);
        logic [3:0] be;
        be = '0;
        for (int i = 0; i < (1 << size); i++) be[off+i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_rep(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] w;
        int n;
        n = 1 << size;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = wd[8*(k % n) +: 8];
        return w;
    endfunction

    // ---------------- 32-bit transaction driver/observer ----------------
    int          o_end, o_nacc, o_nwe, o_noe;
    bit          o_done, o_err, o_unstable, o_tmo, o_cs_end;
    logic [1:0]  o_code;
    logic [31:0] o_rdata, o_maddr, o_mwdata;
    logic [3:0]  o_be;

    // ready_at: index of the ACCESS cycle (0-based) in which mem_ready is high.
    task automatic run32(input bit wr, input logic [1:0] size, input bit sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mrdata, input int ready_at);
        bit fin;
        fin = 1'b0;
        o_end = -1; o_nacc = 0; o_nwe = 0; o_noe = 0;
        o_done = 0; o_err = 0; o_unstable = 0; o_tmo = 0; o_cs_end = 0;
        o_code = '0; o_rdata = '0; o_maddr = '0; o_mwdata = '0; o_be = '0;
        a_req = 1'b1; a_wr = wr; a_size = size; a_sign = sign; a_addr = addr;
        a_wdata = wdata; a_mem_rdata = mrdata; a_mem_ready = 1'b0;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (a_done || a_err) begin
                fin = 1'b1; o_end = cyc; o_done = a_done; o_err = a_err;
                o_code = a_err_code; o_rdata = a_rdata; o_cs_end = a_cs;
                a_req = 1'b0;
            end
            if (a_cs) begin
                if (o_nacc == 0) begin
                    o_be = a_be; o_maddr = a_maddr; o_mwdata = a_mwdata;
                end else if (a_be !== o_be || a_maddr !== o_maddr || a_mwdata !== o_mwdata) begin
                    o_unstable = 1'b1;
                end
                if (a_we) o_nwe++;
                if (a_oe) o_noe++;
                a_mem_ready = (o_nacc == ready_at);
                o_nacc++;
            end else begin
                a_mem_ready = 1'b0;
            end
        end
        o_tmo = !fin;
        a_req = 1'b0; a_mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- 64-bit transaction driver/observer ----------------
    int          p_end;
    bit          p_done;
    logic [63:0] p_rdata, p_mwdata;
    logic [31:0] p_maddr;
    logic [7:0]  p_be;

    task automatic run64(input bit wr, input logic [1:0] size, input bit sign,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] mrdata);
        bit fin;
        fin = 1'b0;
        p_end = -1; p_done = 0; p_rdata = '0; p_mwdata = '0; p_maddr = '0; p_be = '0;
        b_req = 1'b1; b_wr = wr; b_size = size; b_sign = sign; b_addr = addr;
        b_wdata = wdata; b_mem_rdata = mrdata; b_mem_ready = 1'b0;
        for (int cyc = 1; cyc <= 20 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (b_done || b_err) begin
                fin = 1'b1; p_end = cyc; p_done = b_done; p_rdata = b_rdata; b_req = 1'b0;
            end
            if (b_cs) begin
                p_be = b_be; p_maddr = b_maddr; p_mwdata = b_mwdata; b_mem_ready = 1'b1;
            end else begin
                b_mem_ready = 1'b0;
            end
        end
        b_req = 1'b0; b_mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_rdata, a_done, a_err, a_err_code, a_busy, a_cs, a_we, a_oe, a_maddr, a_be, a_mwdata} !== '0) begin
            failures++;
            $display("FAIL reset32: rdata=%h done=%b err=%b code=%b busy=%b cs=%b addr=%h be=%b wdata=%h, want all 0",
                     a_rdata, a_done, a_err, a_err_code, a_busy, a_cs, a_maddr, a_be, a_mwdata);
        end
        checks++;
        if ({b_rdata, b_done, b_err, b_err_code, b_busy, b_cs, b_we, b_oe, b_maddr, b_be, b_mwdata} !== '0) begin
            failures++;
            $display("FAIL reset64: rdata=%h cs=%b be=%b wdata=%h, want all 0", b_rdata, b_cs, b_be, b_mwdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b0 || a_cs !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b cs=%b, want 0 0", a_busy, a_cs);
        end
    endtask

    task automatic test_word_load;
        run32(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        checks++;
        if (o_done !== 1'b1 || o_end != 2 || o_tmo) begin
            failures++;
            $display("FAIL word_load_lat: done=%b at cycle %0d, want done at 2", o_done, o_end);
        end
        checks++;
        if (o_be !== 4'b1111 || o_maddr !== 32'h100 || o_noe != 1 || o_nwe != 0) begin
            failures++;
            $display("FAIL word_load_strobes: be=%b addr=%h oe=%0d we=%0d, want 1111 100 1 0", o_be, o_maddr, o_noe, o_nwe);
        end
        checks++;
        if (o_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL word_load_data: rdata=%h, want deadbeef", o_rdata);
        end
    endtask

    task automatic test_byte_sign;
        run32(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8011_2233, 0);
        checks++;
        if (o_be !== 4'b1000 || o_rdata !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL byte_signed: be=%b rdata=%h, want 1000 ffffff80", o_be, o_rdata);
        end
        run32(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8011_2233, 0);
        checks++;
        if (o_rdata !== 32'h0000_0080) begin
            failures++;
            $display("FAIL byte_unsigned: rdata=%h, want 00000080", o_rdata);
        end
    endtask

    task automatic test_half_store;
        run32(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h1234_5678, 3);
        checks++;
        if (o_maddr !== 32'h200 || o_be !== 4'b1100 || o_mwdata !== 32'hABCD_ABCD) begin
            failures++;
            $display("FAIL half_store_bus: addr=%h be=%b wdata=%h, want 200 1100 abcdabcd", o_maddr, o_be, o_mwdata);
        end
        checks++;
        if (o_nwe != 4 || o_nacc != 4 || o_end != 5 || o_done !== 1'b1 || o_unstable) begin
            failures++;
            $display("FAIL half_store_timing: we_cycles=%0d access=%0d done_cyc=%0d unstable=%b, want 4 4 5 0",
                     o_nwe, o_nacc, o_end, o_unstable);
        end
        checks++;
        if (o_rdata !== 32'h0000_0080 || o_cs_end !== 1'b0) begin
            failures++;
            $display("FAIL store_keeps_rdata: rdata=%h cs_at_done=%b, want 00000080 0", o_rdata, o_cs_end);
        end
    endtask

    task automatic test_fault;
        run32(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        checks++;
        if (o_err !== 1'b1 || o_end != 1 || o_code !== 2'b01 || o_nacc != 0) begin
            failures++;
            $display("FAIL misaligned: err=%b cyc=%0d code=%b cs_cycles=%0d, want 1 1 01 0", o_err, o_end, o_code, o_nacc);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_err_code !== 2'b01 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL err_code_held: code=%b err=%b, want 01 0", a_err_code, a_err);
        end
        run32(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 0);
        checks++;
        if (o_err !== 1'b1 || o_end != 1 || o_code !== 2'b11 || o_nacc != 0) begin
            failures++;
            $display("FAIL illegal_size: err=%b cyc=%0d code=%b cs_cycles=%0d, want 1 1 11 0", o_err, o_end, o_code, o_nacc);
        end
    endtask

    task automatic test_timeout;
        run32(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h5555_AAAA, -1);
        checks++;
        if (o_err !== 1'b1 || o_done !== 1'b0 || o_code !== 2'b10 || o_nacc != TMO || o_end != TMO + 1) begin
            failures++;
            $display("FAIL timeout: err=%b done=%b code=%b access=%0d cyc=%0d, want 1 0 10 %0d %0d",
                     o_err, o_done, o_code, o_nacc, o_end, TMO, TMO + 1);
        end
        checks++;
        if (o_rdata !== 32'h0000_0080) begin
            failures++;
            $display("FAIL timeout_rdata_held: rdata=%h, want 00000080", o_rdata);
        end
        run32(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h5555_AAAA, TMO - 1);
        checks++;
        if (o_done !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'h5555_AAAA || o_code !== 2'b00) begin
            failures++;
            $display("FAIL ready_wins: done=%b err=%b rdata=%h code=%b, want 1 0 5555aaaa 00", o_done, o_err, o_rdata, o_code);
        end
    endtask

    task automatic test_reset_mid;
        a_req = 1'b1; a_wr = 1'b0; a_size = 2'b10; a_addr = 32'h40; a_mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_cs !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_access: cs=%b, want 1", a_cs);
        end
        a_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({a_rdata, a_done, a_err, a_err_code, a_busy, a_cs, a_we, a_oe, a_maddr, a_be, a_mwdata} !== '0) begin
            failures++;
            $display("FAIL async_reset: cs=%b oe=%b addr=%h be=%b rdata=%h busy=%b, want all 0",
                     a_cs, a_oe, a_maddr, a_be, a_rdata, a_busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_done !== 1'b0 || a_err !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_pulse: done=%b err=%b busy=%b, want 0 0 0", a_done, a_err, a_busy);
        end
    endtask

    task automatic test_dword;
        logic [63:0] mem;
        mem = {$urandom, $urandom};
        run64(1'b0, 2'b11, 1'b0, 32'h8, 64'h0, mem);
        checks++;
        if (p_done !== 1'b1 || p_end != 2 || p_be !== 8'hFF || p_maddr !== 32'h8 || p_rdata !== mem) begin
            failures++;
            $display("FAIL dword_load: done=%b cyc=%0d be=%h addr=%h rdata=%h, want 1 2 ff 8 %h",
                     p_done, p_end, p_be, p_maddr, p_rdata, mem);
        end
        run64(1'b1, 2'b10, 1'b0, 32'h14, 64'h1234_5678, 64'h0);
        checks++;
        if (p_be !== 8'hF0 || p_maddr !== 32'h10 || p_mwdata !== 64'h1234_5678_1234_5678 || p_rdata !== mem) begin
            failures++;
            $display("FAIL word_store64: be=%h addr=%h wdata=%h rdata=%h", p_be, p_maddr, p_mwdata, p_rdata);
        end
        run64(1'b0, 2'b01, 1'b1, 32'h1E, 64'h0, 64'hF00D_0000_0000_0000);
        checks++;
        if (p_be !== 8'hC0 || p_rdata !== 64'hFFFF_FFFF_FFFF_F00D) begin
            failures++;
            $display("FAIL half_load64: be=%h rdata=%h, want c0 fffffffffffff00d", p_be, p_rdata);
        end
    endtask

    task automatic test_random;
        logic [31:0] held, addr, wdata, mem, exp_rd;
        logic [1:0]  size, exp_code;
        bit          wr, sign, exp_done;
        int          ready_at, n, off, exp_end, exp_nacc;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        held = '0;
        for (int it = 0; it < 60; it++) begin
            wr = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            sign = 1'($urandom_range(0, 1));
            addr = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'($urandom_range(0, 3));
            wdata = $urandom;
            mem = $urandom;
            ready_at = $urandom_range(0, 5);
            n = 1 << size;
            off = int'(addr[1:0]);
            exp_done = 1'b0; exp_code = 2'b00;
            if (size == 2'b11) begin
                exp_code = 2'b11; exp_end = 1; exp_nacc = 0;
            end else if ((off % n) != 0) begin
                exp_code = 2'b01; exp_end = 1; exp_nacc = 0;
            end else if (ready_at < TMO) begin
                exp_done = 1'b1; exp_end = 2 + ready_at; exp_nacc = ready_at + 1;
            end else begin
                exp_code = 2'b10; exp_end = TMO + 1; exp_nacc = TMO;
            end
            run32(wr, size, sign, addr, wdata, mem, ready_at);
            checks++;
            if (o_done !== exp_done || o_err !== !exp_done || o_end != exp_end || o_nacc != exp_nacc || o_tmo) begin
                failures++;
                $display("FAIL rand_flow[%0d]: done=%b err=%b cyc=%0d access=%0d, want %b %b %0d %0d",
                         it, o_done, o_err, o_end, o_nacc, exp_done, !exp_done, exp_end, exp_nacc);
            end
            checks++;
            if (o_code !== exp_code) begin
                failures++;
                $display("FAIL rand_code[%0d]: code=%b, want %b", it, o_code, exp_code);
            end
            if (exp_done) begin
                checks++;
                if (o_be !== m_be(size, off) || o_maddr !== (addr & 32'hFFFF_FFFC) ||
                    o_mwdata !== m_rep(size, wdata) || o_nwe != (wr ? exp_nacc : 0) ||
                    o_noe != (wr ? 0 : exp_nacc) || o_unstable || o_cs_end) begin
                    failures++;
                    $display("FAIL rand_bus[%0d]: be=%b addr=%h wdata=%h we=%0d oe=%0d unstable=%b, want %b %h %h",
                             it, o_be, o_maddr, o_mwdata, o_nwe, o_noe, o_unstable,
                             m_be(size, off), addr & 32'hFFFF_FFFC, m_rep(size, wdata));
                end
                if (!wr) held = m_load(size, sign, off, mem);
            end
            exp_rd = held;
            checks++;
            if (o_rdata !== exp_rd) begin
                failures++;
                $display("FAIL rand_rdata[%0d]: rdata=%h, want %h (wr=%b size=%b sign=%b addr=%h mem=%h)",
                         it, o_rdata, exp_rd, wr, size, sign, addr, mem);
            end
        end
    endtask

    initial begin
        a_req = 0; a_wr = 0; a_size = 0; a_sign = 0; a_addr = 0; a_wdata = 0;
        a_mem_rdata = 0; a_mem_ready = 0;
        b_req = 0; b_wr = 0; b_size = 0; b_sign = 0; b_addr = 0; b_wdata = 0;
        b_mem_rdata = 0; b_mem_ready = 0;
        test_reset;
        test_word_load;
        test_byte_sign;
        test_half_store;
        test_fault;
        test_timeout;
        test_reset_mid;
        test_dword;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_if.md
# mem_bus_if

Parametrised memory bus interface between the core's control path and external RAM. It replaces hardwired chip-select/write-enable/output-enable ties and the one-cycle `ram_ready` assumption with a request/done handshake that does the following:
- drives `mem_cs`/`mem_we`/`mem_oe` per access;
- steers byte lanes for byte, halfword, word and (when wide) doubleword accesses;
- sign- or zero-extends loads;
- flags misaligned accesses and memory timeouts.

## Interface
- `DATA_W`, 32: memory data width; legal values are 32 or 64.
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 255: maximum ACCESS cycles waiting for `mem_ready`; range 1 to 65535.
- Reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous active-high reset.
- `req` input 1: access request, sampled only in IDLE.
- `wr` input 1: 1 = store, 0 = load.
- `size` input 2: access size. 00 = byte, 01 = half, 10 = word, 11 = doubleword (legal only when `DATA_W` = 64).
- `sign` input 1: sign-extend load data.
- `addr` input `ADDR_W`: byte address.
- `wdata` input `DATA_W`: store data, right-justified.
- `rdata` output `DATA_W`: extended load data; valid while `done` is high.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: one-cycle error pulse.
- `err_code` output 2: 01 = misaligned, 10 = timeout, 11 = illegal size. Held until the next accept.
- `busy` output 1: high from the cycle after accept until the block returns to IDLE.
- `mem_cs`, `mem_we`, `mem_oe` output 1 each: RAM strobes.
- `mem_addr` output `ADDR_W`: lane-aligned address, with the low log2(`DATA_W`/8) bits zero.
- `mem_be` output `DATA_W`/8: byte-lane enables.
- `mem_wdata` output `DATA_W`: store data replicated across lanes.
- `mem_rdata` input `DATA_W`: RAM read data.
- `mem_ready` input 1: RAM completion, sampled in ACCESS.

## Operation
- **States:** IDLE, ACCESS, RESP, FAULT.
- **IDLE + `req`:** latch `wr`, `size`, `sign`, `addr` and `wdata`, then check the request.
  - Illegal size (`size` = 11 with `DATA_W` = 32) -> FAULT, `err_code` = 11.
  - Misaligned -> FAULT, `err_code` = 01.
  - Otherwise -> ACCESS, with the timeout counter cleared.
- **Misaligned:** the address is not a multiple of the access size.
  - Half with `addr[0]` = 1.
  - Word with `addr[1:0]` != 0.
  - Doubleword with `addr[2:0]` != 0.
- **ACCESS:**
  - Strobes: `mem_cs` = 1, `mem_we` = `wr`, `mem_oe` = !`wr`.
  - Byte enables: `mem_be` = size mask shifted left by the lane offset (the low address bits).
  - Ready handling:
    - `mem_ready` = 1 -> capture the extracted and extended read data into `rdata` -> RESP.
    - `mem_ready` = 0 with the counter at `TIMEOUT`-1 -> FAULT, `err_code` = 10.
    - Otherwise increment the counter.
- **RESP:** `done` = 1 -> IDLE.
- **FAULT:** `err` = 1 -> IDLE. No memory strobe is ever raised for a misaligned or illegal request.
- **Load extraction:**
  - Shift `mem_rdata` right by 8 × offset.
  - Mask to the access size.
  - Fill the upper bits with the top data bit if `sign` = 1, else with zeros.
- **Store data:**
  - `mem_wdata` = the `wdata` low byte, half or word replicated across the bus.
  - Doubleword and full-width accesses pass through unchanged.
- **Held latches:** `rdata` is held until the next load completes. Stores leave `rdata` unchanged.
- **`req` outside IDLE:** ignored. The requester holds `req` until it sees `done` or `err`. A `req` still high in the IDLE cycle after `done` starts a new access.

## Timing
- **Reset values:** state IDLE, counter 0. All outputs are 0, including `rdata`, `err_code`, `mem_addr`, `mem_wdata` and `mem_be`.
- **Reset mid-access:** strobes drop asynchronously and no `done` or `err` pulse is issued.
- **Registered outputs:** `mem_*`, `done`, `err` and `rdata` come from flops; there is no combinational path from `req` or `mem_ready` to any output.
- **Best case:** `req` at cycle 0; ACCESS with `mem_ready` high at cycle 1; `done` at cycle 2; IDLE at cycle 3.
- **Wait states:** each ACCESS cycle with `mem_ready` low adds one cycle.
- **Timeout:** `mem_ready` low for `TIMEOUT` consecutive ACCESS cycles -> `err` one cycle later. `mem_ready` rising in that last ACCESS cycle wins over the timeout.
- **Fault latency:** `req` at cycle 0 -> `err` at cycle 1.
- **Strobe stability:** `mem_cs`, `mem_addr`, `mem_be` and `mem_wdata` are stable for the whole ACCESS interval and drop in the RESP/FAULT cycle.

## Structure
- **Package `mem_bus_pkg`:**
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_DWORD`);
  - `err_code` constants;
  - the state enum;
  - a function for the lane-offset width, log2(`DATA_W`/8).
- **Sub-module `mem_lane_align`:** a combinational block (parameter `DATA_W`) holding the byte-enable generation, write replication and read extract/extend. It is instantiated once.
- **Top level:** holds the FSM, latches and timeout counter.

## Test plan
- **Word load, no wait:** `DATA_W` = 32, load word at 0x100, `mem_rdata` = 0xDEADBEEF, `mem_ready` high in the first ACCESS cycle. Require `mem_be` = 1111, `done` at cycle 2, `rdata` = 0xDEADBEEF.
- **Sign-extended byte load:** load byte at 0x103 with `sign` = 1, `mem_rdata` = 0x80112233. Require `mem_be` = 1000, `rdata` = 0xFFFFFF80. With `sign` = 0, require `rdata` = 0x00000080.
- **Half store with wait states:** store half 0xABCD at 0x202 with 3 wait states. Require `mem_addr` = 0x200, `mem_be` = 1100, `mem_wdata` = 0xABCDABCD, `mem_we` = 1 for 4 cycles, and `done` at cycle 5.
- **Misaligned and illegal:** word load at 0x101 -> `err` at cycle 1, `err_code` = 01, `mem_cs` never high. `size` = 11 with `DATA_W` = 32 -> `err_code` = 11.
- **Timeout:** `TIMEOUT` = 4 with `mem_ready` held low -> exactly 4 ACCESS cycles, then `err` with `err_code` = 10. Repeat with `mem_ready` high on the 4th cycle -> `done`, no `err`.
- **Reset and doubleword:**
  - Assert `rst` in the middle of ACCESS -> all outputs are 0 immediately, with no `done` or `err`.
  - `DATA_W` = 64 doubleword load at 0x8 -> `mem_be` = 0xFF and full-width `rdata`.
